// File: rtl/cu_feeder.sv
// cu_feeder: upstream stage of cu_engine. Takes 3-pixel column words from a
// valid/ready source and produces the registered column word plus the 9-bit
// PE enable mask that walks through the systolic fill, run and drain phases.
//
// Handshake: a column is consumed on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the current state and never
// on in_valid. The source must hold in_data stable while in_valid=1 and
// in_ready=0.
module cu_feeder #(
    parameter int ROW_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] data_in,
    output logic [8:0]  pe_en_ctrl,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Counter value of the final column of a pass.
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_LEN - 1);

    state_e            state_q, state_d;
    logic [8:0]        mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       data_q, data_d;
    logic [8:0]        pe_q, pe_d;
    logic              done_q, done_d;
    logic              accept;

    assign in_ready   = (state_q == FILL) || (state_q == RUN);
    assign accept     = in_valid & in_ready;
    assign busy       = (state_q != IDLE);
    assign data_in    = data_q;
    assign pe_en_ctrl = pe_q;
    assign done       = done_q;

    // Next-state and next-output logic; a stall drives pe_d to 0 so the PEs freeze.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pe_d    = 9'h000;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                data_d = 24'h0;
                if (start) begin
                    state_d = FILL;
                    mask_d  = 9'h000;
                    cnt_d   = '0;
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    data_d = in_data;
                    mask_d = {mask_q[5:0], 3'b111};
                    pe_d   = mask_d;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Last column wins over the fill-complete transition.
                    if (cnt_q == LAST_COL) begin
                        state_d = DRAIN;
                    end else if (mask_d == 9'h1FF) begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                data_d = 24'h0;
                mask_d = {mask_q[5:0], 3'b000};
                pe_d   = mask_d;
                if (mask_d == 9'h000) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 9'h000;
            cnt_q   <= '0;
            data_q  <= 24'h0;
            pe_q    <= 9'h000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            done_q  <= done_d;
        end
    end

endmodule
